gctr_frame_feeder: RTL
======================

// Module: gctr_frame_feeder
// PURPOSE
//  Upstream driver of the GCTR n-block cipher: turns a framed plaintext stream (SOF/EOF, partial last word)
//  into the GCTR input interface (words, sop, valid, initial counter block). Builds J0/inc32(J0) from a
//  96-bit IV, zero-masks unused tail bytes, counts frame length, emits len(C) in bits for the GHASH side.
// PARAMETERS
//  NB_BLOCK  128  block width; only 128 supported
//  N_BLOCKS  2    blocks per word
//  NB_DATA   N_BLOCKS*NB_BLOCK  word width
//  NB_IV     96   IV width; only 96 supported
//  NB_LAST   $clog2(N_BLOCKS*16)+1  last-word byte-count width
// PORTS
//  i_clock         in   1        clock
//  i_reset         in   1        synchronous, active-high reset
//  i_data          in   NB_DATA  plaintext word; block b at [b*128+:128], byte 0 of block at MSB [127:120]
//  i_valid         in   1        word qualifier
//  i_sof           in   1        first word of frame (qualified by i_valid)
//  i_eof           in   1        last word of frame (qualified by i_valid); may equal i_sof
//  i_last_bytes    in   NB_LAST  valid bytes in EOF word, 1..N_BLOCKS*16; 0 = full word
//  i_iv            in   NB_IV    IV, sampled on valid SOF
//  o_data          out  NB_DATA  masked word to GCTR plaintext input
//  o_valid         out  1        to GCTR valid
//  o_sop           out  1        to GCTR sop
//  o_initial_cb    out  NB_BLOCK inc32(J0) = {IV,32'd2}; stable from o_sop until next frame
//  o_j0            out  NB_BLOCK J0 = {IV,32'd1}, for tag encryption
//  o_len_c_bits    out  64       frame length in bits, valid with o_len_valid
//  o_len_valid     out  1        one-cycle pulse, cycle after EOF word leaves
//  o_len_err       out  1        sticky: frame exceeded 2^32-2 blocks
//  o_proto_err     out  1        one-cycle pulse: data/EOF outside frame, or SOF inside frame
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; byte counter 0; IV regs 0.
//  - All outputs registered; o_data/o_valid/o_sop lag inputs by exactly 1 cycle. No backpressure.
//  - FSM IDLE: valid&sof -> latch IV, clear counter, o_sop=1 next cycle; eof same cycle -> LEN else BODY.
//    valid&!sof in IDLE -> word dropped, o_valid=0, o_proto_err pulse.
//  - BODY: valid&!sof -> forward word; eof -> LEN. i_valid=0 -> o_valid=0, no state change (gaps allowed).
//    valid&sof in BODY -> o_proto_err pulse, old frame abandoned (no len pulse), new frame started as IDLE.
//  - LEN (1 cycle): o_len_valid=1, o_len_c_bits={byte_cnt,3'b000} zero-extended; -> IDLE. A valid&sof
//    arriving in LEN is accepted as a new frame (back-to-back allowed); len pulse still issued.
//  - Byte counter 36 bits: +N_BLOCKS*16 per non-EOF word, +i_last_bytes (0->full) on EOF word.
//  - Masking on EOF word only: byte k (0..N_BLOCKS*16-1) kept iff k<last_bytes; byte k at bits
//    [(k/16)*128+127-8*(k%16) -: 8]; others forced 0. Non-EOF words pass unmodified.
//  - Block counter 33 bits counts forwarded blocks incl. partial; exceeding 2^32-2 sets o_len_err
//    (cleared only at next SOF or reset); data still forwarded.
//  - o_initial_cb/o_j0 update in the cycle o_sop asserts; held otherwise.
//  - Reset mid-frame: frame discarded, no len pulse, outputs 0 the cycle after reset asserted.
// TESTING
//  1 SOF+EOF single word, IV=96'hCAFEBABEFACEDBADDECAF888, last_bytes=0 -> o_sop,o_valid 1 cyc later,
//    o_initial_cb=IV||00000002, o_j0=IV||00000001, next cyc o_len_valid, len=256.
//  2 3-word frame, EOF last_bytes=5, gap of 2 idle cycles mid-frame -> o_valid follows with 1-cyc lag,
//    EOF word bytes 5..31 zero, len=(64+5)*8=552.
//  3 SOF in BODY after 1 word -> o_proto_err pulse, no len for aborted frame, new frame len correct.
//  4 Data without SOF in IDLE -> dropped, o_proto_err=1 one cycle, o_valid stays 0.
//  5 Back-to-back frames (SOF in LEN cycle) -> both len pulses, second o_sop 1 cyc after its SOF.
//  6 i_reset mid-frame -> all outputs 0 next cycle; following frame starts clean; forced counter near
//    2^32-2 blocks -> o_len_err set, cleared by next SOF.

Source files
------------

// File: rtl/gctr_frame_feeder_if.sv
// rtl/gctr_frame_feeder_if.sv - framed plaintext in / GCTR feed out bundle
interface gctr_frame_feeder_if #(
    parameter int NB_BLOCK = 128,
    parameter int N_BLOCKS = 2,
    parameter int NB_IV    = 96
);
    localparam int NB_DATA = N_BLOCKS * NB_BLOCK;
    localparam int NB_LAST = $clog2(N_BLOCKS * 16) + 1;

    logic [NB_DATA-1:0]  i_data;
    logic                i_valid;
    logic                i_sof;
    logic                i_eof;
    logic [NB_LAST-1:0]  i_last_bytes;
    logic [NB_IV-1:0]    i_iv;

    logic [NB_DATA-1:0]  o_data;
    logic                o_valid;
    logic                o_sop;
    logic [NB_BLOCK-1:0] o_initial_cb;
    logic [NB_BLOCK-1:0] o_j0;
    logic [63:0]         o_len_c_bits;
    logic                o_len_valid;
    logic                o_len_err;
    logic                o_proto_err;

    modport master (
        output i_data, i_valid, i_sof, i_eof, i_last_bytes, i_iv,
        input  o_data, o_valid, o_sop, o_initial_cb, o_j0,
               o_len_c_bits, o_len_valid, o_len_err, o_proto_err
    );

    modport slave (
        input  i_data, i_valid, i_sof, i_eof, i_last_bytes, i_iv,
        output o_data, o_valid, o_sop, o_initial_cb, o_j0,
               o_len_c_bits, o_len_valid, o_len_err, o_proto_err
    );
endinterface

// File: rtl/gctr_frame_feeder.sv
// rtl/gctr_frame_feeder.sv - framed plaintext to GCTR input adapter with J0 build, tail masking, length count
module gctr_frame_feeder #(
    parameter int NB_BLOCK = 128,
    parameter int N_BLOCKS = 2,
    parameter int NB_IV    = 96,
    parameter int NB_DATA  = N_BLOCKS * NB_BLOCK,
    parameter int NB_LAST  = $clog2(N_BLOCKS * 16) + 1
) (
    input logic                 i_clock,
    input logic                 i_reset,
    gctr_frame_feeder_if.slave  bus
);
    localparam int                 NB_BYTES   = N_BLOCKS * 16;
    localparam logic [NB_LAST-1:0] FULL_BYTES = NB_LAST'(NB_BYTES);
    localparam logic [32:0]        BLK_LIMIT  = 33'h0_FFFF_FFFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_LEN
    } state_t;

    state_t              state_q, state_d;
    logic [35:0]         byte_cnt_q, byte_cnt_d;
    logic [32:0]         blk_cnt_q, blk_cnt_d;
    logic [NB_DATA-1:0]  data_q, data_d;
    logic                valid_q, valid_d;
    logic                sop_q, sop_d;
    logic [NB_BLOCK-1:0] cb_q, cb_d;
    logic [NB_BLOCK-1:0] j0_q, j0_d;
    logic [63:0]         len_bits_q, len_bits_d;
    logic                len_valid_q, len_valid_d;
    logic                len_err_q, len_err_d;
    logic                proto_err_q, proto_err_d;

    logic                start;
    logic                accept;
    logic [NB_LAST-1:0]  eff_last;
    logic [NB_LAST-1:0]  word_bytes;
    logic [NB_LAST-1:0]  word_blocks;
    logic [35:0]         byte_base;
    logic [32:0]         blk_base;
    logic [NB_DATA-1:0]  masked;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        blk_cnt_d   = blk_cnt_q;
        data_d      = '0;
        valid_d     = 1'b0;
        sop_d       = 1'b0;
        cb_d        = cb_q;
        j0_d        = j0_q;
        len_bits_d  = len_bits_q;
        len_valid_d = 1'b0;
        len_err_d   = len_err_q;
        proto_err_d = 1'b0;
        start       = 1'b0;
        accept      = 1'b0;

        // Zero or out-of-range tail count both mean a full word.
        eff_last    = ((bus.i_last_bytes == '0) || (bus.i_last_bytes > FULL_BYTES))
                      ? FULL_BYTES : bus.i_last_bytes;
        word_bytes  = bus.i_eof ? eff_last : FULL_BYTES;
        word_blocks = (word_bytes + NB_LAST'(15)) >> 4;

        masked = bus.i_data;
        for (int k = 0; k < NB_BYTES; k++) begin
            if (bus.i_eof && (k >= int'(eff_last))) begin
                masked[(k / 16) * NB_BLOCK + NB_BLOCK - 1 - 8 * (k % 16) -: 8] = 8'h00;
            end
        end

        if (state_q == ST_LEN) begin
            len_valid_d = 1'b1;
            len_bits_d  = {25'd0, byte_cnt_q, 3'b000};
            state_d     = ST_IDLE;
        end

        if (bus.i_valid) begin
            if (bus.i_sof) begin
                start       = 1'b1;
                proto_err_d = (state_q == ST_BODY);
            end else if (state_q == ST_BODY) begin
                accept = 1'b1;
            end else begin
                proto_err_d = 1'b1;
            end
        end

        byte_base = start ? 36'd0 : byte_cnt_q;
        blk_base  = start ? 33'd0 : blk_cnt_q;

        if (start) begin
            sop_d = 1'b1;
            cb_d  = {bus.i_iv, 32'd2};
            j0_d  = {bus.i_iv, 32'd1};
        end

        if (start || accept) begin
            valid_d    = 1'b1;
            data_d     = masked;
            byte_cnt_d = byte_base + 36'(word_bytes);
            blk_cnt_d  = blk_base + 33'(word_blocks);
            len_err_d  = (start ? 1'b0 : len_err_q) | (blk_cnt_d > BLK_LIMIT);
            state_d    = bus.i_eof ? ST_LEN : ST_BODY;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            blk_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            cb_q        <= '0;
            j0_q        <= '0;
            len_bits_q  <= '0;
            len_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            cb_q        <= cb_d;
            j0_q        <= j0_d;
            len_bits_q  <= len_bits_d;
            len_valid_q <= len_valid_d;
            len_err_q   <= len_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_sop        = sop_q;
    assign bus.o_initial_cb = cb_q;
    assign bus.o_j0         = j0_q;
    assign bus.o_len_c_bits = len_bits_q;
    assign bus.o_len_valid  = len_valid_q;
    assign bus.o_len_err    = len_err_q;
    assign bus.o_proto_err  = proto_err_q;
endmodule
